rvv_vec_sequencer: RTL and testbench
====================================

Name: rvv_vec_sequencer

Overview:
Parametrised vector configuration-and-issue sequencer for the RVV datapath. It owns vl/vtype and computes vl from a vsetvl-style request. It strip-mines one vector arithmetic op across the full LMUL register group: it reads source registers, drives the shared vALU, and writes each result register back with tail byte-enables. It sits between instruction decode and vRegFile/vALU, and adds what the single-register pipeline lacks: register grouping, VLMAX clamping, tail-undisturbed writes and an op handshake.

Parameters:
VLEN, 128, vector register width in bits (power of two, >=64)
NREG, 32, architectural vector register count
AVL_W, 9, AVL/vl width in bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  high when IDLE and no op pending acceptance
cfg_sew  in  3  SEW encoding
cfg_lmul  in  3  LMUL encoding
cfg_avl  in  AVL_W  requested AVL
vl  out  AVL_W  current vector length
vtype  out  7  {valid, sew[2:0], lmul[2:0]}
op_valid  in  1  vector op request
op_ready  out  1  op accepted on op_valid&op_ready
op_code  in  3  vALU opcode
op_vs1, op_vs2, op_vd  in  5 each  register group bases
raA, raB  out  5  regfile read addresses
rdA, rdB  in  VLEN  regfile read data (combinational read)
alu_a, alu_b  out  VLEN  vALU operands
alu_op  out  3  vALU opcode
alu_sew  out  3  vALU SEW encoding
alu_res  in  VLEN  vALU result (combinational)
wa  out  5  write address
wd  out  VLEN  write data
wbe  out  VLEN/8  write byte enables
wen  out  1  write strobe
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at op completion
err  out  1  qualifies done; op was illegal, no writes

Behaviour:
- Reset (async, rst=0): state IDLE. vl=0, vtype=0 (invalid). All outputs 0, except cfg_ready=1 and op_ready=1. A reset mid-op drops wen immediately; no further writes.
- SEW decoding: 000=8, 001=16, 010=32, 011=64; other encodings are illegal.
- LMUL decoding: 000=1, 001=2, 010=4, 011=8; 1xx (fractional) is illegal.
- Config handling: accepted on cfg_valid&cfg_ready, and only in IDLE.
  - Legal: vtype={1,sew,lmul}; VLMAX=(VLEN/SEW)*LMUL; vl=min(cfg_avl,VLMAX). Both update on the next edge.
  - Illegal: vtype=7'b0, vl=0.
- Priority: if cfg_valid and op_valid are both high in IDLE, config wins and op_ready=0 that cycle. cfg_ready=0 and op_ready=0 while busy.
- Op acceptance at edge T: capture op fields, vl and vtype. Register count n=ceil(vl*SEW/VLEN).
- Illegal op, checked at acceptance: vtype.valid=0, or any of vs1/vs2/vd not a multiple of LMUL.
  - Go to DONE; done=1 and err=1 at T+1; no writes.
- vl=0 op (legal): DONE at T+1, done=1, err=0, no writes.
- FSM states: IDLE -> READ -> EXEC -> WB -> (READ if i<n-1, else DONE) -> IDLE. Group index i starts at 0.
  - READ: raA=vs1+i, raB=vs2+i, taken mod NREG. Capture rdA/rdB at end of cycle.
  - EXEC: alu_a/alu_b from the captured registers, alu_op=op_code, alu_sew=sew. Capture alu_res into wd at end of cycle.
  - WB: wen=1, wa=vd+i, wbe = tail mask. i increments at end of cycle.
  - DONE: done=1 for one cycle, then IDLE.
- Tail mask: E=VLEN/SEW. active=min(E, vl-i*E). wbe bits [active*SEW/8-1:0] set, upper bits clear (tail undisturbed).
- Latency: writes occur at T+3, T+6, …, T+3n. done is at T+3n+1.
- Read-after-write: register i+1 reads occur after register i's WB edge, so an overlapping vd/vs group sees already-written data.
- alu_a, alu_b, raA, raB, wa, wd and wbe hold their last value outside their active state. wen is 0 outside WB.

Test Plan:
- Config basic: SEW=32 (010), LMUL=2 (001), AVL=5 -> vl=5, vtype=7'b1010001. Same config with AVL=20 -> vl=8 (clamped to VLMAX).
- Illegal config: LMUL=100 -> vtype=0, vl=0. A following op (vs1=0, vs2=2, vd=4) -> done&err at T+1, wen never asserted.
- Strip-mine with tail: vl=5, SEW=32, LMUL=2, op vs1=2, vs2=4, vd=6.
  - Writes wa=6 at T+3 with wbe=16'hFFFF; wa=7 at T+6 with wbe=16'h000F.
  - done at T+7. Addresses: raA=2 then 3; raB=4 then 5.
- Misaligned group and vl=0: LMUL=4 with vd=6 -> err at T+1. vl=0 with valid vtype -> done, err=0 at T+1, no writes.
- Priority and busy: cfg_valid & op_valid in IDLE -> config applied, op held off that cycle. cfg_valid during busy -> cfg_ready=0 and vl unchanged until IDLE.
- Reset mid-op: LMUL=8, SEW=8, vl=128; pulse rst low during the second WB -> wen drops at once, vl=0, vtype=0, state IDLE, done never pulses.

Source files
------------

// File: rtl/rvv_vec_sequencer.sv
// Vector configuration and issue sequencer: owns vl/vtype, clamps vl to VLMAX and
// strip-mines one vALU op across an LMUL register group with tail-undisturbed writes.
module rvv_vec_sequencer #(
  parameter int unsigned VLEN  = 128,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AVL_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_sew,
  input  logic [2:0]        cfg_lmul,
  input  logic [AVL_W-1:0]  cfg_avl,
  output logic [AVL_W-1:0]  vl,
  output logic [6:0]        vtype,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [4:0]        op_vs1,
  input  logic [4:0]        op_vs2,
  input  logic [4:0]        op_vd,
  output logic [4:0]        raA,
  output logic [4:0]        raB,
  input  logic [VLEN-1:0]   rdA,
  input  logic [VLEN-1:0]   rdB,
  output logic [VLEN-1:0]   alu_a,
  output logic [VLEN-1:0]   alu_b,
  output logic [2:0]        alu_op,
  output logic [2:0]        alu_sew,
  input  logic [VLEN-1:0]   alu_res,
  output logic [4:0]        wa,
  output logic [VLEN-1:0]   wd,
  output logic [VLEN/8-1:0] wbe,
  output logic              wen,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int unsigned NB = VLEN / 8;
  localparam logic [NB:0] MaskOne = {{NB{1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWb, StDone} state_e;
  state_e state_q, state_d;

  logic [AVL_W-1:0] vl_q, vl_d;
  logic [6:0]       vtype_q, vtype_d;
  logic [2:0]       code_q, code_d;
  logic [4:0]       vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic [3:0]       i_q, i_d, n_q, n_d;
  logic             err_q, err_d;
  logic [4:0]       ra_a_q, ra_a_d, ra_b_q, ra_b_d, wa_q, wa_d;
  logic [VLEN-1:0]  a_q, a_d, b_q, b_d, wd_q, wd_d;
  logic [NB-1:0]    wbe_q, wbe_d;

  logic        cfg_fire, op_fire, op_bad, cfg_legal, last_reg;
  int unsigned sew_bits, lmul_n, elems, n_calc, cfg_vlmax, active, nbytes;
  logic [NB:0] mask_ext;

  // Decode of the current vtype, group sizing and tail mask for register i
  always_comb begin
    cfg_fire  = cfg_valid && (state_q == StIdle);
    op_fire   = op_valid && (state_q == StIdle) && !cfg_valid;
    sew_bits  = 32'd8 << vtype_q[4:3];
    lmul_n    = 32'd1 << vtype_q[1:0];
    elems     = VLEN / sew_bits;
    n_calc    = (32'(vl_q) * sew_bits + VLEN - 1) / VLEN;
    op_bad    = !vtype_q[6] || (32'(op_vs1) % lmul_n != 0) || (32'(op_vs2) % lmul_n != 0) ||
                (32'(op_vd) % lmul_n != 0);
    cfg_legal = !cfg_sew[2] && !cfg_lmul[2];
    cfg_vlmax = (VLEN / (32'd8 << cfg_sew[1:0])) << cfg_lmul[1:0];
    active    = 32'd0;
    if (32'(vl_q) > 32'(i_q) * elems) begin
      active = 32'(vl_q) - 32'(i_q) * elems;
    end
    if (active > elems) begin
      active = elems;
    end
    nbytes    = active * sew_bits / 8;
    mask_ext  = (MaskOne << nbytes) - MaskOne;
    last_reg  = (32'(i_q) + 32'd1 >= 32'(n_q));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (op_fire) begin
          state_d = (op_bad || vl_q == '0) ? StDone : StRead;
        end
      end
      StRead:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = last_reg ? StDone : StRead;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded handshake and strobe outputs
  always_comb begin
    cfg_ready = (state_q == StIdle);
    op_ready  = (state_q == StIdle) && !cfg_valid;
    busy      = (state_q != StIdle);
    wen       = (state_q == StWb);
    done      = (state_q == StDone);
    err       = (state_q == StDone) && err_q;
  end

  // Datapath next-state: config, op capture, read/exec/writeback registers
  always_comb begin
    vl_d    = vl_q;
    vtype_d = vtype_q;
    code_d  = code_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    vd_d    = vd_q;
    i_d     = i_q;
    n_d     = n_q;
    err_d   = err_q;
    ra_a_d  = ra_a_q;
    ra_b_d  = ra_b_q;
    wa_d    = wa_q;
    a_d     = a_q;
    b_d     = b_q;
    wd_d    = wd_q;
    wbe_d   = wbe_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_fire) begin
          if (cfg_legal) begin
            vtype_d = {1'b1, cfg_sew, cfg_lmul};
            vl_d    = (32'(cfg_avl) < cfg_vlmax) ? cfg_avl : AVL_W'(cfg_vlmax);
          end else begin
            vtype_d = '0;
            vl_d    = '0;
          end
        end else if (op_fire) begin
          code_d = op_code;
          vs1_d  = op_vs1;
          vs2_d  = op_vs2;
          vd_d   = op_vd;
          i_d    = '0;
          n_d    = 4'(n_calc);
          err_d  = op_bad;
          // Address outputs only move when a real strip-mine begins
          if (!op_bad && vl_q != '0) begin
            ra_a_d = op_vs1;
            ra_b_d = op_vs2;
          end
        end
      end
      StRead: begin
        a_d = rdA;
        b_d = rdB;
      end
      StExec: begin
        wd_d  = alu_res;
        wa_d  = 5'((32'(vd_q) + 32'(i_q)) % NREG);
        wbe_d = mask_ext[NB-1:0];
      end
      StWb: begin
        i_d = i_q + 4'd1;
        if (!last_reg) begin
          ra_a_d = 5'((32'(vs1_q) + 32'(i_q) + 32'd1) % NREG);
          ra_b_d = 5'((32'(vs2_q) + 32'(i_q) + 32'd1) % NREG);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vl_q    <= '0;
      vtype_q <= '0;
      code_q  <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      i_q     <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
      ra_a_q  <= '0;
      ra_b_q  <= '0;
      wa_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
      wbe_q   <= '0;
    end else begin
      vl_q    <= vl_d;
      vtype_q <= vtype_d;
      code_q  <= code_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      vd_q    <= vd_d;
      i_q     <= i_d;
      n_q     <= n_d;
      err_q   <= err_d;
      ra_a_q  <= ra_a_d;
      ra_b_q  <= ra_b_d;
      wa_q    <= wa_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
      wbe_q   <= wbe_d;
    end
  end

  assign vl      = vl_q;
  assign vtype   = vtype_q;
  assign raA     = ra_a_q;
  assign raB     = ra_b_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = code_q;
  assign alu_sew = vtype_q[5:3];
  assign wa      = wa_q;
  assign wd      = wd_q;
  assign wbe     = wbe_q;

endmodule

// File: tb/tb_rvv_vec_sequencer.sv
// Scoreboard bench for rvv_vec_sequencer: a register-file/vALU environment, a
// queue-based reference model of the strip-mined op, and a decoupled monitor.
module tb_rvv_vec_sequencer;
  localparam int unsigned VLEN  = 128;
  localparam int unsigned NREG  = 32;
  localparam int unsigned AVL_W = 9;
  localparam int unsigned NB    = VLEN / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_valid = 1'b0, op_valid = 1'b0;
  logic cfg_ready, op_ready;
  logic [2:0] cfg_sew = '0, cfg_lmul = '0, op_code = '0;
  logic [AVL_W-1:0] cfg_avl = '0;
  logic [AVL_W-1:0] vl;
  logic [6:0] vtype;
  logic [4:0] op_vs1 = '0, op_vs2 = '0, op_vd = '0;
  logic [4:0] raA, raB, wa;
  logic [VLEN-1:0] rdA, rdB, alu_a, alu_b, alu_res, wd;
  logic [2:0] alu_op, alu_sew;
  logic [NB-1:0] wbe;
  logic wen, busy, done, err;

  always #5 clk = ~clk;

  rvv_vec_sequencer #(.VLEN(VLEN), .NREG(NREG), .AVL_W(AVL_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sew(cfg_sew), .cfg_lmul(cfg_lmul),
    .cfg_avl(cfg_avl), .vl(vl), .vtype(vtype),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_vs1(op_vs1), .op_vs2(op_vs2), .op_vd(op_vd),
    .raA(raA), .raB(raB), .rdA(rdA), .rdB(rdB),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sew(alu_sew), .alu_res(alu_res),
    .wa(wa), .wd(wd), .wbe(wbe), .wen(wen), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [VLEN-1:0] alu_fn(input logic [2:0] op, input logic [VLEN-1:0] a,
                                             input logic [VLEN-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a + b + VLEN'(op);
    endcase
  endfunction

  // Environment: register file with combinational read, byte-enabled write
  logic [VLEN-1:0] rf[NREG];
  logic [VLEN-1:0] seed_v[NREG];
  logic [VLEN-1:0] mdl[NREG];
  bit do_load = 1'b0;
  assign rdA = rf[raA];
  assign rdB = rf[raB];
  assign alu_res = alu_fn(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    if (do_load) begin
      for (int r = 0; r < NREG; r++) rf[r] <= seed_v[r];
    end else if (wen) begin
      for (int bb = 0; bb < NB; bb++) if (wbe[bb]) rf[wa][8*bb+:8] <= wd[8*bb+:8];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [4:0] wa; logic [VLEN-1:0] wd; logic [NB-1:0] wbe; int unsigned cyc; } wr_t;
  typedef struct { logic err; int unsigned cyc; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input bit ok, input string name, input string info);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, info);
  endtask

  // Reference model of architectural config state
  bit m_valid = 1'b0;
  logic [2:0] m_sew = '0, m_lmul = '0;
  int unsigned m_vl = 0;

  function automatic logic [6:0] m_vtype();
    return {m_valid, m_sew, m_lmul};
  endfunction

  task automatic model_cfg(input logic [2:0] s, input logic [2:0] l, input int unsigned avl);
    int unsigned vlmax;
    if (s <= 3'd3 && l <= 3'd3) begin
      vlmax = (VLEN / (8 << s)) * (1 << l);
      m_valid = 1'b1; m_sew = s; m_lmul = l;
      m_vl = (avl < vlmax) ? avl : vlmax;
    end else begin
      m_valid = 1'b0; m_sew = '0; m_lmul = '0; m_vl = 0;
    end
  endtask

  task automatic reload_regs();
    for (int r = 0; r < NREG; r++)
      for (int w = 0; w < VLEN / 32; w++) seed_v[r][32*w+:32] = $urandom;
    do_load = 1'b1;
    @(posedge clk); #1;
    do_load = 1'b0;
    for (int r = 0; r < NREG; r++) mdl[r] = seed_v[r];
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or completes
  initial begin
    wr_t e;
    dn_t d;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (wen) begin
          if (wr_q.size() == 0) chk(1'b0, "unexpected_write", $sformatf("wa=%0d cyc=%0d", wa, cyc));
          else begin
            e = wr_q.pop_front();
            chk(wa == e.wa && wd == e.wd && wbe == e.wbe && cyc == e.cyc, "write",
                $sformatf("got wa=%0d wbe=%h cyc=%0d wd=%h want wa=%0d wbe=%h cyc=%0d wd=%h",
                          wa, wbe, cyc, wd, e.wa, e.wbe, e.cyc, e.wd));
          end
        end
        if (done) begin
          if (dn_q.size() == 0) chk(1'b0, "unexpected_done", $sformatf("err=%0b cyc=%0d", err, cyc));
          else begin
            d = dn_q.pop_front();
            chk(err == d.err && cyc == d.cyc && wr_q.size() == 0, "done",
                $sformatf("got err=%0b cyc=%0d pending_writes=%0d want err=%0b cyc=%0d",
                          err, cyc, wr_q.size(), d.err, d.cyc));
          end
        end
      end
    end
  end

  // Each driver task starts and ends just after a rising edge
  task automatic do_cfg(input logic [2:0] s, input logic [2:0] l, input int unsigned avl);
    cfg_sew = s; cfg_lmul = l; cfg_avl = AVL_W'(avl); cfg_valid = 1'b1;
    @(negedge clk);
    chk(cfg_ready == 1'b1, "cfg_ready_idle", $sformatf("got %0b want 1", cfg_ready));
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    model_cfg(s, l, avl);
    chk(vl == AVL_W'(m_vl) && vtype == m_vtype(), "cfg",
        $sformatf("got vl=%0d vtype=%b want vl=%0d vtype=%b", vl, vtype, m_vl, m_vtype()));
  endtask

  task automatic issue_op(input logic [2:0] code, input int unsigned vs1, input int unsigned vs2,
                          input int unsigned vd, output int unsigned t);
    int unsigned lm, sb, e, n, act, nb;
    bit got;
    logic [VLEN-1:0] a, b, r;
    wr_t w;
    dn_t d;
    op_code = code; op_vs1 = 5'(vs1); op_vs2 = 5'(vs2); op_vd = 5'(vd); op_valid = 1'b1;
    got = 1'b0;
    t = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = op_ready;
    end
    if (!got) begin
      chk(1'b0, "op_accept", "op_ready never rose within 50 cycles");
      op_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    t = cyc;
    lm = 1 << m_lmul;
    if (!m_valid || vs1 % lm != 0 || vs2 % lm != 0 || vd % lm != 0) begin
      d.err = 1'b1; d.cyc = t; dn_q.push_back(d);
    end else if (m_vl == 0) begin
      d.err = 1'b0; d.cyc = t; dn_q.push_back(d);
    end else begin
      sb = 8 << m_sew;
      e = VLEN / sb;
      n = (m_vl * sb + VLEN - 1) / VLEN;
      for (int k = 0; k < n; k++) begin
        a = mdl[(vs1 + k) % NREG];
        b = mdl[(vs2 + k) % NREG];
        r = alu_fn(code, a, b);
        act = (m_vl - k * e < e) ? m_vl - k * e : e;
        nb = act * sb / 8;
        for (int bb = 0; bb < NB; bb++) w.wbe[bb] = (bb < nb);
        w.wa = 5'((vd + k) % NREG); w.wd = r; w.cyc = t + 3 * k + 2;
        wr_q.push_back(w);
        for (int bb = 0; bb < NB; bb++) if (w.wbe[bb]) mdl[w.wa][8*bb+:8] = r[8*bb+:8];
      end
      d.err = 1'b0; d.cyc = t + 3 * n; dn_q.push_back(d);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = !busy && wr_q.size() == 0 && dn_q.size() == 0;
    end
    if (!ok) begin
      chk(1'b0, "op_complete", $sformatf("busy=%0b writes_left=%0d dones_left=%0d",
                                         busy, wr_q.size(), dn_q.size()));
      wr_q.delete(); dn_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [2:0] code, input int unsigned vs1, input int unsigned vs2,
                        input int unsigned vd);
    int unsigned t;
    issue_op(code, vs1, vs2, vd, t);
    wait_idle();
  endtask

  initial begin
    int unsigned t, ndone, old_vl, lm, nops;
    bit reached;
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, ndone, old_vl, lm, nops;
    bit reached;
    for (int r = 0; r < NREG; r++)
      for (int w = 0; w < VLEN / 32; w++) seed_v[r][32*w+:32] = $urandom;
    do_load = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_load = 1'b0;
    for (int r = 0; r < NREG; r++) mdl[r] = seed_v[r];
    chk(vl == '0 && vtype == '0 && cfg_ready && op_ready && !busy && !done && !err && !wen &&
        wbe == '0 && wa == '0 && raA == '0 && alu_op == '0, "reset_state",
        $sformatf("vl=%0d vtype=%b cfg_ready=%0b op_ready=%0b busy=%0b done=%0b wen=%0b wbe=%h",
                  vl, vtype, cfg_ready, op_ready, busy, done, wen, wbe));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic config and VLMAX clamp
    do_cfg(3'b010, 3'b001, 5);
    chk(vtype == 7'b1010001, "cfg_vtype_const", $sformatf("got %b want 1010001", vtype));
    do_cfg(3'b010, 3'b001, 20);
    chk(vl == 9'd8, "cfg_clamp_const", $sformatf("got %0d want 8", vl));

    // Illegal config, then op under it
    do_cfg(3'b010, 3'b100, 10);
    run_op(3'd0, 0, 2, 4);

    // Strip-mine with tail and address sequence
    do_cfg(3'b010, 3'b001, 5);
    issue_op(3'd0, 2, 4, 6, t);
    @(negedge clk);
    chk(raA == 5'd2 && raB == 5'd4, "read_addr_0", $sformatf("got %0d/%0d want 2/4", raA, raB));
    repeat (3) @(negedge clk);
    chk(raA == 5'd3 && raB == 5'd5, "read_addr_1", $sformatf("got %0d/%0d want 3/5", raA, raB));
    wait_idle();

    // Misaligned group, then vl=0 with a valid vtype
    do_cfg(3'b000, 3'b010, 50);
    run_op(3'd1, 0, 4, 6);
    do_cfg(3'b000, 3'b000, 0);
    run_op(3'd1, 1, 2, 3);

    // Config and op together in IDLE: config wins
    cfg_sew = 3'b001; cfg_lmul = 3'b000; cfg_avl = 9'd3; cfg_valid = 1'b1;
    op_code = 3'd2; op_vs1 = 5'd1; op_vs2 = 5'd2; op_vd = 5'd3; op_valid = 1'b1;
    @(negedge clk);
    chk(!op_ready && cfg_ready, "priority_ready", $sformatf("op_ready=%0b cfg_ready=%0b", op_ready, cfg_ready));
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    model_cfg(3'b001, 3'b000, 3);
    chk(!busy && vl == 9'd3, "priority_cfg", $sformatf("busy=%0b vl=%0d want busy=0 vl=3", busy, vl));
    run_op(3'd2, 1, 2, 3);

    // Config request while busy is held off
    do_cfg(3'b000, 3'b001, 30);
    old_vl = m_vl;
    issue_op(3'd4, 0, 2, 2, t);
    cfg_sew = 3'b011; cfg_lmul = 3'b000; cfg_avl = 9'd1; cfg_valid = 1'b1;
    @(negedge clk);
    chk(!cfg_ready && !op_ready && busy, "busy_ready", $sformatf("cfg_ready=%0b op_ready=%0b busy=%0b",
                                                            cfg_ready, op_ready, busy));
    @(negedge clk);
    chk(vl == AVL_W'(old_vl), "busy_vl_hold", $sformatf("got %0d want %0d", vl, old_vl));
    #1 cfg_valid = 1'b0;
    wait_idle();
    chk(vl == AVL_W'(old_vl), "busy_vl_after", $sformatf("got %0d want %0d", vl, old_vl));

    // Randomized configs and ops
    for (int it = 0; it < 40; it++) begin
      do_cfg(3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), $urandom_range(0, 300));
      nops = $urandom_range(1, 3);
      for (int k = 0; k < nops; k++) begin
        lm = m_valid ? (1 << m_lmul) : 1;
        if ($urandom_range(0, 3) != 0)
          run_op(3'($urandom_range(0, 7)), ($urandom_range(0, 31) / lm) * lm,
                 ($urandom_range(0, 31) / lm) * lm, ($urandom_range(0, 31) / lm) * lm);
        else
          run_op(3'($urandom_range(0, 7)), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31));
      end
    end

    // Reset during the second writeback of a long op
    do_cfg(3'b000, 3'b011, 200);
    issue_op(3'd0, 8, 16, 24, t);
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      @(negedge clk);
      reached = (cyc == t + 5);
    end
    chk(reached && wen, "second_wb_reached", $sformatf("reached=%0b wen=%0b", reached, wen));
    #1 rst = 1'b0;
    #1;
    chk(!wen && !busy && !done && vl == '0 && vtype == '0 && cfg_ready, "reset_mid_op",
        $sformatf("wen=%0b busy=%0b done=%0b vl=%0d vtype=%b", wen, busy, done, vl, vtype));
    wr_q.delete();
    dn_q.delete();
    model_cfg(3'b111, 3'b111, 0);
    reload_regs();
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || wen) ndone++;
    end
    chk(ndone == 0, "no_done_after_reset", $sformatf("got %0d done/wen cycles want 0", ndone));
    @(posedge clk); #1;

    // Sequencer still works after the mid-op reset
    do_cfg(3'b001, 3'b001, 11);
    run_op(3'd5, 4, 6, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
